// File: rtl/apb_pkg.sv
// Shared constants for the APB master bridge: FSM state encodings and default widths.
package apb_pkg;

  localparam int APB_ADDR_W         = 16;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  function automatic logic apb_is_busy(input logic [1:0] state);
    return (state != ST_IDLE);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the APB master bridge; only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);
  // Fires on the LIMIT-th consecutive not-ready ACCESS cycle.
  assign o_expired = i_enable && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_enable && !w_at_last) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Native single-cycle request port to two-phase APB master, one transfer outstanding.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [ADDR_W-1:0] apbm_paddr,
  output logic [DATA_W-1:0] apbm_pwdata,
  input  logic [DATA_W-1:0] apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_req_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic w_accept;
  logic w_complete;
  logic w_timeout;
  logic w_done;

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_complete = (r_state == ST_ACCESS) && apbm_pready;
  assign w_done     = w_complete || w_timeout;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == ST_SETUP),
    .i_enable ((r_state == ST_ACCESS) && !apbm_pready),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // APB control strobes are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= !apb_is_busy(w_state_nxt);
      r_psel       <= apb_is_busy(w_state_nxt);
      r_penable    <= (w_state_nxt == ST_ACCESS);
      r_resp_valid <= w_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwrite <= 1'b0;
      r_paddr  <= {ADDR_W{1'b0}};
      r_pwdata <= {DATA_W{1'b0}};
    end else if (w_accept) begin
      r_pwrite <= req_write;
      r_paddr  <= req_addr;
      r_pwdata <= req_wdata;
    end else begin
      r_pwrite <= r_pwrite;
      r_paddr  <= r_paddr;
      r_pwdata <= r_pwdata;
    end
  end

  // A forced timeout completion reports an error with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_rdata <= {DATA_W{1'b0}};
      r_resp_err   <= 1'b0;
    end else if (w_complete) begin
      r_resp_rdata <= r_pwrite ? {DATA_W{1'b0}} : apbm_prdata;
      r_resp_err   <= apbm_pslverr;
    end else if (w_timeout) begin
      r_resp_rdata <= {DATA_W{1'b0}};
      r_resp_err   <= 1'b1;
    end else begin
      r_resp_rdata <= r_resp_rdata;
      r_resp_err   <= r_resp_err;
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign apbm_psel    = r_psel;
  assign apbm_penable = r_penable;
  assign apbm_pwrite  = r_pwrite;
  assign apbm_paddr   = r_paddr;
  assign apbm_pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed scoreboard bench for apb_master_bridge (default build, or APB_TIMEOUT_EN with limit 8).
module tb_apb_master_bridge;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          apbm_psel;
  logic          apbm_penable;
  logic          apbm_pwrite;
  logic [AW-1:0] apbm_paddr;
  logic [DW-1:0] apbm_pwdata;
  logic [DW-1:0] apbm_prdata;
  logic          apbm_pready;
  logic          apbm_pslverr;

  int total = 0;
  int bad   = 0;
  logic [DW:0] sb_q[$];

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .apbm_psel(apbm_psel), .apbm_penable(apbm_penable), .apbm_pwrite(apbm_pwrite),
    .apbm_paddr(apbm_paddr), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
    .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [DW:0] e;
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=unexpected_resp expected=queued_resp", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e[DW-1:0]);
      chk1({tag, "_err"}, resp_err, e[DW]);
    end
  endtask

  task automatic wait_resp(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (resp_valid) begin
        pop_chk(tag);
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s_timeout observed=no_resp expected=resp_valid", tag);
    end
  endtask

  task automatic run_xfer(input string tag, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rd,
                          input logic e, input int waits);
    logic got;
    sb_q.push_back({e, (w ? {DW{1'b0}} : rd)});
    apbm_pready = 1'b0; apbm_pslverr = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1'b1; break; end
      tick();
    end
    chk1({tag, "_accept"}, got, 1'b1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_setup"}, {30'd0, apbm_psel, apbm_penable}, 32'd2);
    tick();
    repeat (waits) tick();
    apbm_pready = 1'b1; apbm_prdata = rd; apbm_pslverr = e;
    tick();
    wait_resp(tag, 20);
    apbm_pready = 1'b0; apbm_pslverr = 1'b0; apbm_prdata = {DW{1'b0}};
  endtask

  initial begin
    int n;
    int rv_cnt;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    apbm_prdata = '0; apbm_pready = 1'b0; apbm_pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk("rst_outs", {26'd0, resp_valid, resp_err, apbm_psel, apbm_penable, apbm_pwrite, 1'b0}, 32'd0);
    chk("rst_data", resp_rdata | {16'd0, apbm_paddr} | apbm_pwdata, 32'd0);
    rst = 1'b0;
    tick();

    // Write with pready tied high; request inputs change after capture.
    apbm_pready = 1'b1; apbm_prdata = 32'hDEAD_BEEF;
    chk1("t1_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0004; req_wdata = 32'hCAFE_F00D;
    sb_q.push_back({1'b0, 32'h0});
    tick();
    req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 32'h0;
    chk("t1_c1_ctl", {29'd0, apbm_psel, apbm_penable, req_ready}, 32'd4);
    chk("t1_c1_paddr", {16'd0, apbm_paddr}, 32'h0004);
    chk("t1_c1_pwdata", apbm_pwdata, 32'hCAFE_F00D);
    chk1("t1_c1_pwrite", apbm_pwrite, 1'b1);
    tick();
    chk("t1_c2_ctl", {29'd0, apbm_psel, apbm_penable, req_ready}, 32'd6);
    chk("t1_c2_paddr", {16'd0, apbm_paddr}, 32'h0004);
    chk("t1_c2_pwdata", apbm_pwdata, 32'hCAFE_F00D);
    tick();
    chk1("t1_c3_resp_valid", resp_valid, 1'b1);
    if (resp_valid) pop_chk("t1_resp");
    chk("t1_c3_ctl", {29'd0, apbm_psel, apbm_penable, req_ready}, 32'd1);
    chk("t1_c3_paddr_hold", {16'd0, apbm_paddr}, 32'h0004);
    tick();
    chk1("t1_c4_pulse", resp_valid, 1'b0);
    apbm_pready = 1'b0; apbm_prdata = '0;

    // Read with four wait states.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
    sb_q.push_back({1'b0, 32'h0000_0003});
    tick();
    req_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_wait_ctl", {30'd0, apbm_psel, apbm_penable}, 32'd3);
      chk1("t2_wait_rv", resp_valid, 1'b0);
      tick();
    end
    apbm_pready = 1'b1; apbm_prdata = 32'h0000_0003;
    chk("t2_last_ctl", {30'd0, apbm_psel, apbm_penable}, 32'd3);
    tick();
    chk1("t2_resp_valid", resp_valid, 1'b1);
    if (resp_valid) pop_chk("t2_resp");
    apbm_pready = 1'b0; apbm_prdata = 32'h0;
    tick();
    chk1("t2_pulse", resp_valid, 1'b0);
    chk("t2_rdata_hold", resp_rdata, 32'h0000_0003);

    // Slave error, then a clean transfer clears it.
    run_xfer("t3_err_rd", 1'b0, 16'h0008, 32'h0, 32'h1234_5678, 1'b1, 0);
    chk1("t3_err_hold", resp_err, 1'b1);
    run_xfer("t3_clean_wr", 1'b1, 16'h000C, 32'h0000_0055, 32'hFFFF_FFFF, 1'b0, 1);

    // Back-to-back writes with req_valid held high.
    tick();
    apbm_pready = 1'b1;
    n = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 32'hA000_0000;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (resp_valid) pop_chk("t4_resp");
      chk1("t4_req_ready", req_ready, (cyc % 3) == 0);
      if ((cyc % 3) == 1) chk("t4_setup_paddr", {16'd0, apbm_paddr}, 32'h0010 + cyc / 3);
      if (req_valid && req_ready) begin
        chk("t4_accept_cycle", cyc, n * 3);
        sb_q.push_back({1'b0, 32'h0});
        n++;
      end
      tick();
      if (n == 4) req_valid = 1'b0;
      req_addr = 16'h0010 + n[15:0];
      req_wdata = 32'hA000_0000 + n;
    end
    chk("t4_accepted", n, 32'd4);
    apbm_pready = 1'b0;

    // Reset in the ACCESS phase of a read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0020;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t5_in_access", {30'd0, apbm_psel, apbm_penable}, 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_async_ctl", {29'd0, apbm_psel, apbm_penable, resp_valid}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    apbm_pready = 1'b1; apbm_prdata = 32'h7777_7777;
    tick();
    rv_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid) rv_cnt++;
      tick();
    end
    chk1("t5_ready_after", req_ready, 1'b1);
    chk("t5_no_resp", rv_cnt, 32'd0);
    apbm_pready = 1'b0; apbm_prdata = '0;

    // Responder never ready.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0030;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef APB_TIMEOUT_EN
    sb_q.push_back({1'b1, 32'h0});
    apbm_prdata = 32'h5A5A_5A5A;
    wait_resp("t6_timeout", 20);
    chk1("t6_ready_idle", req_ready, 1'b1);
    chk1("t6_psel_idle", apbm_psel, 1'b0);
    apbm_prdata = '0;
`else
    rv_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (resp_valid) rv_cnt++;
      tick();
    end
    chk("t6_no_resp", rv_cnt, 32'd0);
    chk("t6_still_access", {29'd0, apbm_psel, apbm_penable, req_ready}, 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk1("t6_recovered", req_ready, 1'b1);
`endif

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator-side bridge: converts the single-cycle native CPU port (sel/write/addr/wdata) into a compliant two-phase APB master transfer.
- Drives APB responders such as the testbench manager and peripheral blocks.
- Waits on pready and returns read data and error to the CPU through a registered response pulse.
- Single clock domain; one outstanding transfer at a time.

Parameters:
ADDR_W, 16, APB/native address width
DATA_W, 32, APB/native data width
TIMEOUT_CYCLES, 255, max ACCESS-phase cycles before forced error (used only with APB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  native request present
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
req_ready  output  1  bridge can accept a request this cycle
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  read data; 0 for writes
resp_err  output  1  pslverr, or timeout, of the completed transfer
apbm_psel  output  1  APB select
apbm_penable  output  1  APB enable
apbm_pwrite  output  1  APB direction
apbm_paddr  output  ADDR_W  APB address
apbm_pwdata  output  DATA_W  APB write data
apbm_prdata  input  DATA_W  APB read data
apbm_pready  input  1  APB ready
apbm_pslverr  input  1  APB slave error

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: every output is 0 except req_ready, which is 1. The FSM resets to IDLE.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture write/addr/wdata into registers and go to SETUP.
  - SETUP: psel=1, penable=0, req_ready=0. Unconditionally go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. Hold until pready=1. On pready, register the response and go to IDLE.
- Response timing:
  - resp_valid=1 for exactly the cycle after pready is sampled high in ACCESS.
  - resp_rdata = prdata for reads, 0 for writes. resp_err = pslverr.
  - resp_rdata and resp_err hold their value until the next completion.
- Latency: accept at cycle 0, SETUP at 1, ACCESS at 2. With pready=1 at cycle 2, resp_valid=1 at cycle 3. Each pready=0 cycle adds one cycle.
- Back-to-back: at the resp_valid cycle the state is IDLE and req_ready=1, so a new request is accepted in that same cycle. Sustained throughput is 1 transfer per 3 cycles.
- APB output stability: paddr, pwrite and pwdata come from the capture registers and stay stable from SETUP through the final ACCESS cycle. While psel=0 the previous values are held.
- Ignored inputs:
  - req_* are ignored while req_ready=0; the bench must hold or retry.
  - pready and pslverr are ignored outside ACCESS.
- Reset mid-transfer: psel and penable drop asynchronously, the transfer is abandoned, and no resp_valid is issued.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle while pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the bridge forces completion: resp_valid=1, resp_err=1, resp_rdata=0, state goes to IDLE.
  - pready arriving in that same cycle wins, giving normal completion.
- Not defined: no counter logic exists, and ACCESS waits indefinitely for pready.

Decomposition:
- Shared package/include apb_pkg:
  - state encodings IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2;
  - default ADDR_W and DATA_W;
  - default TIMEOUT_CYCLES.
- One natural sub-module, apb_timeout_cnt (clear, enable, expired output), instantiated only under APB_TIMEOUT_EN.

Test Plan:
1. Write, addr=16'h0004, wdata=32'hCAFE_F00D, pready tied 1 -> SETUP at cycle 1, ACCESS at cycle 2, resp_valid at cycle 3 with resp_err=0 and resp_rdata=0; paddr/pwdata stable on cycles 1-2.
2. Read, addr=16'h0000, prdata=32'h0000_0003, pready low for 4 ACCESS cycles -> psel/penable held for 5 ACCESS cycles; resp_valid=1 with resp_rdata=32'h3 exactly one cycle after pready.
3. Read with pslverr=1 alongside pready -> resp_err=1; the next clean transfer returns resp_err=0.
4. req_valid held high continuously for 4 writes -> accepts on cycles 0, 3, 6, 9; req_ready is low during SETUP and ACCESS.
5. rst asserted during ACCESS of a read -> psel, penable and resp_valid go 0 immediately; after release req_ready=1 and no response pulse appears.
6. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 -> forced completion with resp_err=1 and resp_rdata=0, then IDLE; without the macro the bridge is still in ACCESS after 100 cycles.
